// File: rtl/key_debounce.sv
// Multi-key push-button conditioner: 2-flop synchronizer, shared sample tick,
// and a per-key debounce/hold FSM producing a level plus press, release and
// long-press/auto-repeat pulses. All outputs are registered.
module key_debounce #(
  parameter int NUM_KEYS       = 4,
  parameter int TICK_DIV       = 12000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int TW   = $clog2(TICK_DIV);
  localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  // Repeat period of 0 means "no repeat"; keep the constant in range anyway.
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] s;

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running sample-tick divider shared by every key.
  always_ff @(posedge clk) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // Two-flop synchronizer; loads "released" in reset so a held key re-debounces.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t        state, state_nx;
    logic [DW-1:0] db_cnt, db_cnt_nx;
    logic [HW-1:0] hold_cnt, hold_cnt_nx;
    logic          long_seen, long_seen_nx;
    logic          level_q, level_nx;
    logic          press_q, press_nx;
    logic          release_q, release_nx;
    logic          long_q, long_nx;

    assign key_level[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_long[k]    = long_q;

    // Per-key state and registered outputs.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state     <= IDLE;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        long_seen <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_nx;
        db_cnt    <= db_cnt_nx;
        hold_cnt  <= hold_cnt_nx;
        long_seen <= long_seen_nx;
        level_q   <= level_nx;
        press_q   <= press_nx;
        release_q <= release_nx;
        long_q    <= long_nx;
      end
    end

    // Next state: a change of s always beats a coincident tick, so the
    // aborted transition never counts that tick.
    always_comb begin
      state_nx     = state;
      db_cnt_nx    = db_cnt;
      hold_cnt_nx  = hold_cnt;
      long_seen_nx = long_seen;
      level_nx     = level_q;
      press_nx     = 1'b0;
      release_nx   = 1'b0;
      long_nx      = 1'b0;
      case (state)
        IDLE: begin
          if (s[k]) begin
            state_nx  = PRESS_DB;
            db_cnt_nx = '0;
          end
        end
        PRESS_DB: begin
          if (!s[k]) begin
            state_nx = IDLE;
          end else if (tick) begin
            if (db_cnt == DB_LAST) begin
              state_nx     = HELD;
              level_nx     = 1'b1;
              press_nx     = 1'b1;
              hold_cnt_nx  = '0;
              long_seen_nx = 1'b0;
            end else begin
              db_cnt_nx = db_cnt + DW'(1);
            end
          end
        end
        HELD: begin
          if (!s[k]) begin
            // Hold timing freezes while the release is being qualified.
            state_nx  = RELEASE_DB;
            db_cnt_nx = '0;
          end else if (tick) begin
            if (!long_seen) begin
              if (hold_cnt == LONG_LAST) begin
                long_nx      = 1'b1;
                long_seen_nx = 1'b1;
                hold_cnt_nx  = '0;
              end else begin
                hold_cnt_nx = hold_cnt + HW'(1);
              end
            end else if (REPEAT_TICKS > 0) begin
              if (hold_cnt == REP_LAST) begin
                long_nx     = 1'b1;
                hold_cnt_nx = '0;
              end else begin
                hold_cnt_nx = hold_cnt + HW'(1);
              end
            end
            // Repeat disabled: hold_cnt simply parks after the first pulse.
          end
        end
        RELEASE_DB: begin
          if (s[k]) begin
            state_nx = HELD;
          end else if (tick) begin
            if (db_cnt == DB_LAST) begin
              state_nx   = IDLE;
              level_nx   = 1'b0;
              release_nx = 1'b1;
            end else begin
              db_cnt_nx = db_cnt + DW'(1);
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: table-driven segments, hand-written
// corner sequences and random stimulus, all compared every cycle against an
// event-level model (run length in ticks, total held ticks).
module tb_key_debounce;

  localparam int NK = 4;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int LT = 8;
  localparam int RT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_level, key_press, key_release, key_long;

  key_debounce #(
    .NUM_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB),
    .LONG_TICKS(LT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int acc_p, acc_r, acc_l;
  bit mdl_on = 1'b0;

  // Reference model state.
  logic [NK-1:0] m_sync1, m_sync2, m_lev, m_prs, m_rel, m_lng;
  int  m_c;
  bit  m_run [NK];
  int  m_rt  [NK];
  int  m_held[NK];

  typedef struct {
    logic [NK-1:0] kn;
    int            cycles;
    logic [NK-1:0] level;
    int            np;
    int            nr;
    int            nl;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic check_range(input string nm, input int v, input int lo, input int hi);
    n_total++;
    if (v >= lo && v <= hi) n_pass++;
    else $display("FAIL %s: got %0d, want %0d..%0d", nm, v, lo, hi);
  endtask

  // Model: level flips once s has differed from it for DB ticks, not counting
  // a tick on the cycle the difference first appears. Long pulses fall on
  // held-tick totals LT, LT+RT, LT+2RT, ...
  task automatic model_step();
    logic [NK-1:0] s;
    bit tk;
    if (!rst_n) begin
      m_sync1 = '1; m_sync2 = '1; m_c = 0;
      m_lev = '0; m_prs = '0; m_rel = '0; m_lng = '0;
      for (int k = 0; k < NK; k++) begin
        m_run[k] = 1'b0; m_rt[k] = 0; m_held[k] = 0;
      end
    end else begin
      tk = ((m_c % TD) == TD - 1);
      m_c = m_c + 1;
      s = ~m_sync2;
      m_prs = '0; m_rel = '0; m_lng = '0;
      for (int k = 0; k < NK; k++) begin
        if (s[k] != m_lev[k]) begin
          if (!m_run[k]) begin
            m_run[k] = 1'b1; m_rt[k] = 0;
          end else if (tk) begin
            m_rt[k]++;
            if (m_rt[k] == DB) begin
              m_lev[k] = s[k];
              m_run[k] = 1'b0;
              if (s[k]) begin m_prs[k] = 1'b1; m_held[k] = 0; end
              else m_rel[k] = 1'b1;
            end
          end
        end else begin
          if (m_lev[k] && !m_run[k] && tk) begin
            m_held[k]++;
            if (m_held[k] == LT || (RT > 0 && m_held[k] > LT && (m_held[k] - LT) % RT == 0))
              m_lng[k] = 1'b1;
          end
          m_run[k] = 1'b0;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = key_n;
    end
  endtask

  // One clock: model follows the edge, DUT compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (mdl_on)
      check("cycle", 32'({key_level, key_press, key_release, key_long}),
                     32'({m_lev, m_prs, m_rel, m_lng}));
    acc_p += $countones(key_press);
    acc_r += $countones(key_release);
    acc_l += $countones(key_long);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic logic [NK-1:0] sig(input int sel);
    case (sel)
      0:       return key_press;
      1:       return key_release;
      default: return key_long;
    endcase
  endfunction

  task automatic wait_pulse(input int sel, input int k, input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      cyc();
      if (sig(sel)[k]) begin lat = i; break; end
    end
  endtask

  task automatic clr_acc();
    acc_p = 0; acc_r = 0; acc_l = 0;
  endtask

  initial begin
    int lat, lat2;
    logic [NK-1:0] lv;
    tbl[0] = '{4'hF,  20, 4'h0, 0, 0, 0};
    tbl[1] = '{4'hE,  20, 4'h1, 1, 0, 0};
    tbl[2] = '{4'hE,  80, 4'h1, 0, 0, 4};
    tbl[3] = '{4'hF,  20, 4'h0, 0, 1, 0};
    tbl[4] = '{4'hD,   2, 4'h0, 0, 0, 0};
    tbl[5] = '{4'hF,  12, 4'h0, 0, 0, 0};
    tbl[6] = '{4'hB,  20, 4'h4, 1, 0, 0};
    tbl[7] = '{4'hB, 240, 4'h4, 0, 0, 14};
    tbl[8] = '{4'hF,  20, 4'h0, 0, 1, 0};
    tbl[9] = '{4'hF,   8, 4'h0, 0, 0, 0};
    clr_acc();

    // Reset state.
    rst_n = 1'b0; key_n = '1;
    run(2);
    check("reset_outs", 32'({key_level, key_press, key_release, key_long}), 0);
    mdl_on = 1'b1;
    rst_n = 1'b1;

    // Table segments.
    for (int i = 0; i < 10; i++) begin
      key_n = tbl[i].kn;
      clr_acc();
      run(tbl[i].cycles);
      check($sformatf("seg%0d_level", i), 32'(key_level), 32'(tbl[i].level));
      check($sformatf("seg%0d_press", i), acc_p, tbl[i].np);
      check($sformatf("seg%0d_release", i), acc_r, tbl[i].nr);
      check($sformatf("seg%0d_long", i), acc_l, tbl[i].nl);
    end

    // Clean press/release latency on key0.
    clr_acc();
    key_n = 4'hE;
    wait_pulse(0, 0, 20, lat);
    check_range("press_latency", lat, 9, 15);
    check("press_level_same_cycle", 32'(key_level[0]), 1);
    run(80);
    key_n = 4'hF;
    wait_pulse(1, 0, 20, lat);
    check_range("release_latency", lat, 9, 15);
    check("release_level_same_cycle", 32'(key_level[0]), 0);
    check("clean_single_press", acc_p, 1);
    check("clean_single_release", acc_r, 1);
    run(8);

    // Bounce on key1.
    clr_acc();
    for (int i = 0; i < 10; i++) begin
      key_n = (i % 2 == 0) ? 4'hD : 4'hF;
      run(3);
    end
    check("bounce_quiet", acc_p + acc_r + acc_l, 0);
    key_n = 4'hD;
    run(20);
    check("bounce_one_press", acc_p, 1);
    check("bounce_level", 32'(key_level), 32'(4'h2));
    key_n = 4'hF;
    run(24);

    // Release glitch on key3 while held.
    key_n = 4'h7;
    wait_pulse(0, 3, 20, lat);
    check("glitch_accept", (lat > 0) ? 1 : 0, 1);
    clr_acc();
    run(12);
    key_n = 4'hF;
    run(2);
    key_n = 4'h7;
    wait_pulse(2, 3, 40, lat2);
    check_range("glitch_long_delay", (lat2 < 0) ? -1 : 14 + lat2, 32, 36);
    check("glitch_no_release", acc_r, 0);
    check("glitch_level_held", 32'(key_level[3]), 1);
    key_n = 4'hF;
    run(24);

    // Reset mid-debounce and mid-hold with key0 held throughout.
    key_n = 4'hE;
    run(6);
    rst_n = 1'b0;
    cyc();
    check("rst_db_outs", 32'({key_level, key_press, key_release, key_long}), 0);
    rst_n = 1'b1;
    wait_pulse(0, 0, 20, lat);
    check_range("rst_db_repress", lat, 9, 15);
    run(10);
    rst_n = 1'b0;
    cyc();
    check("rst_held_outs", 32'({key_level, key_press, key_release, key_long}), 0);
    rst_n = 1'b1;
    wait_pulse(0, 0, 20, lat);
    check_range("rst_held_repress", lat, 9, 15);
    key_n = 4'hF;
    run(24);

    // Simultaneous press on keys 0 and 1.
    key_n = 4'hC;
    wait_pulse(0, 0, 20, lat);
    check("simul_press", 32'(key_press), 32'(4'h3));
    lv = key_level;
    check("simul_level", 32'(lv), 32'(4'h3));
    key_n = 4'hF;
    run(24);

    // Random stimulus, occasional reset.
    for (int i = 0; i < 150; i++) begin
      key_n = 4'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      run($urandom_range(1, 40));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
